// File: rtl/led_pkg.sv
// Shared constants and state encoding for the LED pattern sequencer family.
package led_pkg;

  localparam logic [1:0] CH_WHITE = 2'd0;
  localparam logic [1:0] CH_RED   = 2'd1;
  localparam logic [1:0] CH_GREEN = 2'd2;
  localparam logic [1:0] CH_BLUE  = 2'd3;

  localparam logic PAT_RAMP  = 1'b0;
  localparam logic PAT_CHASE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PIXEL = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

endpackage

// File: rtl/led_pixel_colour.sv
// Combinational pixel colour: picks ramp or chase value, then routes it to
// the selected colour channel(s).
module led_pixel_colour
  import led_pkg::*;
#(
  parameter int CW = 8,
  parameter int IW = 6
) (
  input  logic [CW-1:0] acc,
  input  logic [IW-1:0] idx,
  input  logic [IW-1:0] cp,
  input  logic [1:0]    chan_q,
  input  logic          pattern_q,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b
);

  logic [CW-1:0] v;

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    v = acc;
    if (pattern_q == PAT_CHASE) v = (idx == cp) ? {CW{1'b1}} : '0;

    r = '0;
    g = '0;
    b = '0;
    case (chan_q)
      CH_WHITE: begin
        r = v;
        g = v;
        b = v;
      end
      CH_RED:   r = v;
      CH_GREEN: g = v;
      CH_BLUE:  b = v;
      default:  ;
    endcase
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Pixel-stream generator for addressable LED strips: one RGB slot per encoder
// done, a latch slot at end of frame, and a per-frame animated pattern.
module led_pattern_sequencer
  import led_pkg::*;
#(
  parameter int NUM_PIXELS = 64,
  parameter int CW         = 8,
  parameter int STEP       = 4,
  parameter int PHASE_STEP = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [1:0]    chan,
  input  logic          pattern,
  input  logic          done,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b,
  output logic          latch,
  output logic          frame_done,
  output logic [15:0]   frame_count
);

  localparam int IW = $clog2(NUM_PIXELS);
  localparam logic [IW-1:0] LAST = IW'(NUM_PIXELS - 1);
  localparam logic [CW-1:0] STEP_C = CW'(STEP);
  localparam logic [CW-1:0] PHASE_C = CW'(PHASE_STEP);

  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [IW-1:0] cp, cp_nxt;
  logic [CW-1:0] acc, acc_nxt;
  logic [CW-1:0] phase, phase_nxt;
  logic [1:0]    chan_q, chan_nxt;
  logic          pattern_q, pattern_nxt;
  logic          frame_done_nxt;
  logic [15:0]   frame_count_nxt;
  logic [CW-1:0] col_r, col_g, col_b;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    cp_nxt          = cp;
    acc_nxt         = acc;
    phase_nxt       = phase;
    chan_nxt        = chan_q;
    pattern_nxt     = pattern_q;
    frame_done_nxt  = 1'b0;
    frame_count_nxt = frame_count;

    case (state)
      ST_IDLE: begin
        if (enable) begin
          chan_nxt    = chan;
          pattern_nxt = pattern;
          acc_nxt     = phase;
          idx_nxt     = '0;
          state_nxt   = ST_PIXEL;
        end
      end
      ST_PIXEL: begin
        if (done) begin
          if (idx == LAST) begin
            state_nxt = ST_LATCH;
          end else begin
            idx_nxt = idx + 1'b1;
            acc_nxt = acc + STEP_C;
          end
        end
      end
      ST_LATCH: begin
        if (done) begin
          frame_done_nxt  = 1'b1;
          frame_count_nxt = frame_count + 16'd1;
          phase_nxt       = phase + PHASE_C;
          cp_nxt          = (cp == LAST) ? '0 : cp + 1'b1;
          if (enable) begin
            chan_nxt    = chan;
            pattern_nxt = pattern;
            acc_nxt     = phase_nxt;
            idx_nxt     = '0;
            state_nxt   = ST_PIXEL;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Colour is computed from the upcoming slot so r/g/b can be registered.
  led_pixel_colour #(
    .CW(CW),
    .IW(IW)
  ) u_colour (
    .acc      (acc_nxt),
    .idx      (idx_nxt),
    .cp       (cp_nxt),
    .chan_q   (chan_nxt),
    .pattern_q(pattern_nxt),
    .r        (col_r),
    .g        (col_g),
    .b        (col_b)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx         <= '0;
      cp          <= '0;
      acc         <= '0;
      phase       <= '0;
      chan_q      <= CH_WHITE;
      pattern_q   <= PAT_RAMP;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      latch       <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      idx         <= idx_nxt;
      cp          <= cp_nxt;
      acc         <= acc_nxt;
      phase       <= phase_nxt;
      chan_q      <= chan_nxt;
      pattern_q   <= pattern_nxt;
      r           <= (state_nxt == ST_PIXEL) ? col_r : '0;
      g           <= (state_nxt == ST_PIXEL) ? col_g : '0;
      b           <= (state_nxt == ST_PIXEL) ? col_b : '0;
      latch       <= (state_nxt == ST_LATCH);
      frame_done  <= frame_done_nxt;
      frame_count <= frame_count_nxt;
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench: a 4-pixel strip with STEP=4, plus a STEP=100 copy for
// ramp wraparound, driven through ramp, chase, mode-change, stop and reset.
module tb_led_pattern_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  chan;
  logic        pattern;
  logic        done;
  logic [7:0]  r, g, b;
  logic        latch, frame_done;
  logic [15:0] frame_count;
  logic [7:0]  w_r, w_g, w_b;
  logic        w_latch, w_frame_done;
  logic [15:0] w_frame_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  led_pattern_sequencer #(.NUM_PIXELS(4), .CW(8), .STEP(4), .PHASE_STEP(1)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .chan(chan), .pattern(pattern),
    .done(done), .r(r), .g(g), .b(b), .latch(latch), .frame_done(frame_done),
    .frame_count(frame_count)
  );

  led_pattern_sequencer #(.NUM_PIXELS(4), .CW(8), .STEP(100), .PHASE_STEP(1)) dut_w (
    .clk(clk), .reset_n(reset_n), .enable(enable), .chan(chan), .pattern(pattern),
    .done(done), .r(w_r), .g(w_g), .b(w_b), .latch(w_latch), .frame_done(w_frame_done),
    .frame_count(w_frame_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic slot(input string tag, input int er, input int eg, input int eb,
                      input int el);
    check({tag, ".r"}, 32'(r), 32'(er));
    check({tag, ".g"}, 32'(g), 32'(eg));
    check({tag, ".b"}, 32'(b), 32'(eb));
    check({tag, ".latch"}, 32'(latch), 32'(el));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle done pulse, then a gap so the encoder spacing is realistic.
  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic gap();
    repeat (3) tick();
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; chan = 2'd0; pattern = 1'b0; done = 1'b0;
    tick(); tick();
    slot("reset", 0, 0, 0, 0);
    check("reset.frame_done", 32'(frame_done), 0);
    check("reset.frame_count", 32'(frame_count), 0);

    reset_n = 1'b1;
    tick();
    slot("idle", 0, 0, 0, 0);

    // Frame 0: white ramp 0,4,8,12; wrap copy 0,100,200,44.
    enable = 1'b1;
    tick();
    slot("f0p0", 0, 0, 0, 0);
    check("w.f0p0", 32'(w_r), 0);
    gap(); pulse_done();
    slot("f0p1", 4, 4, 4, 0);
    check("w.f0p1", 32'(w_r), 100);
    gap(); pulse_done();
    slot("f0p2", 8, 8, 8, 0);
    check("w.f0p2", 32'(w_r), 200);
    gap(); pulse_done();
    slot("f0p3", 12, 12, 12, 0);
    check("w.f0p3", 32'(w_r), 44);
    check("w.f0p3.b", 32'(w_b), 44);
    gap(); pulse_done();
    slot("f0latch", 0, 0, 0, 1);
    check("f0latch.frame_done", 32'(frame_done), 0);
    check("f0latch.frame_count", 32'(frame_count), 0);

    // Frame 1: phase 1.
    gap(); pulse_done();
    check("f1.frame_done", 32'(frame_done), 1);
    check("f1.frame_count", 32'(frame_count), 1);
    slot("f1p0", 1, 1, 1, 0);
    tick();
    check("f1.frame_done_low", 32'(frame_done), 0);
    gap(); pulse_done(); slot("f1p1", 5, 5, 5, 0);
    gap(); pulse_done(); slot("f1p2", 9, 9, 9, 0);
    gap(); pulse_done(); slot("f1p3", 13, 13, 13, 0);
    gap(); pulse_done(); slot("f1latch", 0, 0, 0, 1);

    // Mode change during the latch slot takes effect at the next frame start.
    chan = 2'd1; pattern = 1'b1;
    gap(); pulse_done();
    check("f2.frame_count", 32'(frame_count), 2);
    check("f2.frame_done", 32'(frame_done), 1);
    slot("f2p0", 0, 0, 0, 0);
    gap(); pulse_done(); slot("f2p1", 0, 0, 0, 0);
    gap(); pulse_done(); slot("f2p2", 255, 0, 0, 0);
    gap(); pulse_done(); slot("f2p3", 0, 0, 0, 0);
    gap(); pulse_done(); slot("f2latch", 0, 0, 0, 1);

    gap(); pulse_done(); slot("f3p0", 0, 0, 0, 0);
    gap(); pulse_done(); slot("f3p1", 0, 0, 0, 0);
    gap(); pulse_done(); slot("f3p2", 0, 0, 0, 0);
    gap(); pulse_done(); slot("f3p3", 255, 0, 0, 0);
    gap(); pulse_done(); slot("f3latch", 0, 0, 0, 1);

    // Chase pointer wraps 3 -> 0.
    gap(); pulse_done(); slot("f4p0", 255, 0, 0, 0);
    gap(); pulse_done(); slot("f4p1", 0, 0, 0, 0);
    gap(); pulse_done(); slot("f4p2", 0, 0, 0, 0);
    gap(); pulse_done(); slot("f4p3", 0, 0, 0, 0);
    gap(); pulse_done(); slot("f4latch", 0, 0, 0, 1);

    // Frame 5 white ramp, phase 5; chan flips to blue at pixel 1.
    chan = 2'd0; pattern = 1'b0;
    gap(); pulse_done();
    check("f5.frame_count", 32'(frame_count), 5);
    slot("f5p0", 5, 5, 5, 0);
    gap(); pulse_done(); slot("f5p1", 9, 9, 9, 0);
    chan = 2'd3;
    gap(); pulse_done(); slot("f5p2", 13, 13, 13, 0);
    gap(); pulse_done(); slot("f5p3", 17, 17, 17, 0);
    gap(); pulse_done(); slot("f5latch", 0, 0, 0, 1);

    // Frame 6 blue only, phase 6; enable dropped at pixel 2.
    gap(); pulse_done(); slot("f6p0", 0, 0, 6, 0);
    gap(); pulse_done(); slot("f6p1", 0, 0, 10, 0);
    gap(); pulse_done(); slot("f6p2", 0, 0, 14, 0);
    enable = 1'b0;
    gap(); pulse_done(); slot("f6p3", 0, 0, 18, 0);
    gap(); pulse_done(); slot("f6latch", 0, 0, 0, 1);
    gap(); pulse_done();
    check("stop.frame_done", 32'(frame_done), 1);
    check("stop.frame_count", 32'(frame_count), 7);
    slot("stop.idle", 0, 0, 0, 0);
    gap(); pulse_done();
    gap(); pulse_done();
    check("idle_done.frame_count", 32'(frame_count), 7);
    check("idle_done.frame_done", 32'(frame_done), 0);
    slot("idle_done", 0, 0, 0, 0);

    // Restart (phase 7), then async reset at pixel 2.
    chan = 2'd0; enable = 1'b1;
    tick(); slot("f7p0", 7, 7, 7, 0);
    gap(); pulse_done(); slot("f7p1", 11, 11, 11, 0);
    gap(); pulse_done(); slot("f7p2", 15, 15, 15, 0);
    reset_n = 1'b0;
    #1;
    slot("async_reset", 0, 0, 0, 0);
    check("async_reset.frame_count", 32'(frame_count), 0);
    tick();
    reset_n = 1'b1;
    tick();
    slot("restart_p0", 0, 0, 0, 0);
    check("restart.frame_count", 32'(frame_count), 0);
    gap(); pulse_done(); slot("restart_p1", 4, 4, 4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
